instruction_fetch_stage: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Owns the fetch PC, issues word requests to instruction memory over a req/ready handshake, and registers the returned instruction into the IF/ID boundary.
- Supports decode-side stall and branch/jump redirect, including discarding an in-flight response after a redirect.

---
 rtl/instruction_fetch_stage.sv | 158 +++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives a req/ready instruction-memory
// port and registers each returned word, with its PC, into the IF/ID boundary.
module instruction_fetch_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic              fault
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    REQ      = 2'd1,
    HOLD     = 2'd2,
    DROP     = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   ifpc_q, ifpc_d;
  logic [ADDR_W-1:0]   plus4_q, plus4_d;
  logic                fault_q, fault_d;
  logic [ADDR_W-1:0]   pc_seq;

  assign pc_seq = pc_q + PC_STEP;

  // Next-state logic: fetch sequencing first, then redirect overrides it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    valid_d      = stall ? valid_q : 1'b0;
    instr_d      = instr_q;
    ifpc_d       = ifpc_q;
    plus4_d      = plus4_q;
    fault_d      = fault_q;

    case (state_q)
      RST_WAIT: state_d = REQ;
      REQ: begin
        req_addr_d = pc_q;
        if (imem_ready) begin
          pc_d = pc_seq;
          if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end else begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            plus4_d = pc_seq;
          end
        end else begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (!stall) begin
          valid_d = 1'b1;
          instr_d = skid_instr_q;
          ifpc_d  = skid_pc_q;
          plus4_d = skid_pc_q + PC_STEP;
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        if (imem_ready) begin
          state_d = REQ;
        end else begin
          state_d = DROP;
        end
      end
      default: state_d = RST_WAIT;
    endcase

    // A redirect flushes IF/ID and the skid; an unanswered request must still finish in DROP.
    if (redirect) begin
      valid_d      = 1'b0;
      instr_d      = instr_q;
      ifpc_d       = ifpc_q;
      plus4_d      = plus4_q;
      skid_instr_d = {DATA_W{1'b0}};
      skid_pc_d    = {ADDR_W{1'b0}};
      pc_d         = {redirect_pc[ADDR_W-1:2], 2'b00};
      fault_d      = fault_q | (redirect_pc[1:0] != 2'b00);
      case (state_q)
        RST_WAIT: state_d = REQ;
        REQ:      state_d = imem_ready ? REQ : DROP;
        HOLD:     state_d = REQ;
        DROP:     state_d = DROP;
        default:  state_d = RST_WAIT;
      endcase
    end else begin
      fault_d = fault_q;
    end
  end

  // State and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RST_WAIT;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      skid_instr_q <= {DATA_W{1'b0}};
      skid_pc_q    <= {ADDR_W{1'b0}};
      valid_q      <= 1'b0;
      instr_q      <= {DATA_W{1'b0}};
      ifpc_q       <= {ADDR_W{1'b0}};
      plus4_q      <= {ADDR_W{1'b0}};
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      ifpc_q       <= ifpc_d;
      plus4_q      <= plus4_d;
      fault_q      <= fault_d;
    end
  end

  assign imem_req    = (state_q == REQ) || (state_q == DROP);
  assign imem_addr   = (state_q == DROP) ? req_addr_q : pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign if_pc_plus4 = plus4_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed scenarios plus randomized
// traffic checked against an in-order fetch-stream model.
module tb_instruction_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic        if_valid, fault;
  logic [31:0] if_instr, if_pc, if_pc_plus4;

  int checks = 0, errors = 0;
  int wait_cnt = 0, lat = 0, min_lat = 0, max_lat = 0;
  bit mem_block = 1'b0;

  logic        p_rst_n, p_stall, p_redir, p_req, p_ready, p_valid;
  logic [31:0] p_rpc, p_addr, p_instr, p_pc, p_plus4;

  instruction_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Drive inputs and the memory model for one cycle, snapshot pre-edge values, advance.
  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    imem_ready = imem_req && !mem_block && (wait_cnt >= lat);
    imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    p_rst_n = rst_n; p_stall = st; p_redir = rd; p_rpc = rpc;
    p_req = imem_req; p_ready = imem_ready; p_addr = imem_addr;
    p_valid = if_valid; p_instr = if_instr; p_pc = if_pc; p_plus4 = if_pc_plus4;
    @(posedge clk); #1;
    if (!p_rst_n || (p_req && p_ready)) begin
      wait_cnt = 0;
      lat = $urandom_range(max_lat, min_lat);
    end else if (p_req) begin
      wait_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mem_block = 1'b0; min_lat = 0; max_lat = 0;
    rst_n = 1'b0;
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({imem_req, if_valid, fault} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got req/valid/fault=%b required 000", {imem_req, if_valid, fault});
    end
    checks++;
    if ({if_instr, if_pc, if_pc_plus4} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got instr=%h pc=%h pc4=%h required all 0", if_instr, if_pc, if_pc_plus4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    min_lat = 0; max_lat = 0; mem_block = 1'b0;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL zw_first_req: got valid=%b req=%b addr=%h required 0 1 0", if_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      e = 32'(i * 4);
      checks++;
      if ({if_valid, if_pc, if_pc_plus4, if_instr} !== {1'b1, e, e + 32'd4, mem_word(e)}) begin
        errors++; $display("FAIL zw_seq%0d: got v=%b pc=%h pc4=%h instr=%h required pc=%h", i, if_valid, if_pc, if_pc_plus4, if_instr, e);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] e = 32'h0;
    int last = -1, n = 0;
    min_lat = 2; max_lat = 2; mem_block = 1'b0;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      tick(1'b0, 1'b0, 32'h0);
      if (p_req && !p_ready) begin
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, p_addr}) begin
          errors++; $display("FAIL ws_stable: got req=%b addr=%h required 1 %h", imem_req, imem_addr, p_addr);
        end
      end
      if (if_valid) begin
        checks++;
        if ({if_pc, if_instr} !== {e, mem_word(e)}) begin
          errors++; $display("FAIL ws_data: got pc=%h instr=%h required pc=%h", if_pc, if_instr, e);
        end
        if (last >= 0) begin
          checks++;
          if (c - last !== 3) begin
            errors++; $display("FAIL ws_gap: got %0d cycles required 3", c - last);
          end
        end
        last = c; e += 32'd4; n++;
      end
    end
    checks++;
    if (n !== 9) begin
      errors++; $display("FAIL ws_count: got %0d deliveries required 9", n);
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] sp, si;
    min_lat = 0; max_lat = 0; mem_block = 1'b0;
    do_reset();
    repeat (3) tick(1'b0, 1'b0, 32'h0);
    sp = if_pc; si = if_instr;
    checks++;
    if ({if_valid, sp} !== {1'b1, 32'h4}) begin
      errors++; $display("FAIL st_pre: got valid=%b pc=%h required 1 00000004", if_valid, sp);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      checks++;
      if ({if_valid, if_pc, if_pc_plus4, if_instr, imem_req} !== {1'b1, sp, sp + 32'd4, si, 1'b0}) begin
        errors++; $display("FAIL st_hold%0d: got v=%b pc=%h instr=%h req=%b required pc=%h req=0", i, if_valid, if_pc, if_instr, imem_req, sp);
      end
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid, if_pc, if_instr, imem_req, imem_addr} !== {1'b1, sp + 32'd4, mem_word(sp + 32'd4), 1'b1, sp + 32'd8}) begin
      errors++; $display("FAIL st_release: got v=%b pc=%h instr=%h req=%b addr=%h required pc=%h", if_valid, if_pc, if_instr, imem_req, imem_addr, sp + 32'd4);
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid, if_pc} !== {1'b1, sp + 32'd8}) begin
      errors++; $display("FAIL st_resume: got v=%b pc=%h required pc=%h", if_valid, if_pc, sp + 32'd8);
    end
  endtask

  task automatic test_redirect();
    int n = 0;
    min_lat = 0; max_lat = 0; mem_block = 1'b0;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    while (!(imem_req && imem_addr == 32'h10) && n < 20) begin
      tick(1'b0, 1'b0, 32'h0); n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL rd_timeout: got no request to 00000010 within %0d cycles required one", n);
    end
    mem_block = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h100);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h10, 1'b0}) begin
        errors++; $display("FAIL rd_drop%0d: got req=%b addr=%h v=%b required 1 00000010 0", i, imem_req, imem_addr, if_valid);
      end
      if (i < 2) tick(1'b0, 1'b0, 32'h0);
    end
    mem_block = 1'b0;
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid, imem_addr} !== {1'b0, 32'h100}) begin
      errors++; $display("FAIL rd_discard: got v=%b addr=%h required 0 00000100", if_valid, imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
      errors++; $display("FAIL rd_target: got v=%b pc=%h instr=%h required pc=00000100", if_valid, if_pc, if_instr);
    end
    tick(1'b0, 1'b1, 32'h10);
    tick(1'b0, 1'b1, 32'h200);
    checks++;
    if ({if_valid, imem_addr} !== {1'b0, 32'h200}) begin
      errors++; $display("FAIL rd_same_cycle: got v=%b addr=%h required 0 00000200", if_valid, imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
      errors++; $display("FAIL rd_same_target: got v=%b pc=%h instr=%h required pc=00000200", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_wrap_fault();
    min_lat = 0; max_lat = 0; mem_block = 1'b0;
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    checks++;
    if ({if_valid, imem_addr, fault} !== {1'b0, 32'hFFFF_FFFC, 1'b0}) begin
      errors++; $display("FAIL wr_redirect: got v=%b addr=%h fault=%b required 0 fffffffc 0", if_valid, imem_addr, fault);
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid, if_pc, if_pc_plus4, if_instr, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 32'h0}) begin
      errors++; $display("FAIL wr_wrap: got pc=%h pc4=%h addr=%h required fffffffc 00000000 00000000", if_pc, if_pc_plus4, imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wr_after: got v=%b pc=%h required 1 00000000", if_valid, if_pc);
    end
    tick(1'b0, 1'b1, 32'h102);
    checks++;
    if ({fault, imem_addr, if_valid} !== {1'b1, 32'h100, 1'b0}) begin
      errors++; $display("FAIL fa_set: got fault=%b addr=%h v=%b required 1 00000100 0", fault, imem_addr, if_valid);
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL fa_target: got v=%b pc=%h required 1 00000100", if_valid, if_pc);
    end
    repeat (3) tick(1'b0, 1'b1, 32'h40);
    checks++;
    if (fault !== 1'b1) begin
      errors++; $display("FAIL fa_sticky: got fault=%b required 1", fault);
    end
  endtask

  task automatic test_reset_midwait();
    mem_block = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    tick(1'b1, 1'b0, 32'h0);
    checks++;
    if ({imem_req, if_valid, fault, if_instr, if_pc, if_pc_plus4} !== 99'h0) begin
      errors++; $display("FAIL rm_reset: got req=%b v=%b fault=%b instr=%h pc=%h pc4=%h required all 0", imem_req, if_valid, fault, if_instr, if_pc, if_pc_plus4);
    end
    rst_n = 1'b1; mem_block = 1'b0;
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL rm_restart: got req=%b addr=%h required 1 00000000", imem_req, imem_addr);
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
      errors++; $display("FAIL rm_first: got v=%b pc=%h instr=%h required pc=00000000", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_random_traffic();
    logic [31:0] exp_pc = 32'h0, rpc;
    logic        exp_fault = 1'b0, st, rd;
    int          delivered = 0;
    min_lat = 0; max_lat = 3; mem_block = 1'b0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      st  = ($urandom_range(9, 0) < 3);
      rd  = ($urandom_range(19, 0) == 0);
      rpc = $urandom & (($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      tick(st, rd, rpc);
      if (p_req && !p_ready) begin
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, p_addr}) begin
          errors++; $display("FAIL rt_stable@%0d: got req=%b addr=%h required 1 %h", c, imem_req, imem_addr, p_addr);
        end
      end
      if (p_redir) begin
        checks++;
        if (if_valid !== 1'b0) begin
          errors++; $display("FAIL rt_flush@%0d: got v=%b required 0", c, if_valid);
        end
        exp_pc = {p_rpc[31:2], 2'b00};
        exp_fault = exp_fault | (p_rpc[1:0] != 2'b00);
      end else if (p_stall) begin
        checks++;
        if ({if_valid, if_pc, if_pc_plus4, if_instr} !== {p_valid, p_pc, p_plus4, p_instr}) begin
          errors++; $display("FAIL rt_hold@%0d: got v=%b pc=%h instr=%h required v=%b pc=%h instr=%h", c, if_valid, if_pc, if_instr, p_valid, p_pc, p_instr);
        end
      end else if (if_valid) begin
        checks++;
        if ({if_pc, if_pc_plus4, if_instr} !== {exp_pc, exp_pc + 32'd4, mem_word(exp_pc)}) begin
          errors++; $display("FAIL rt_stream@%0d: got pc=%h pc4=%h instr=%h required pc=%h", c, if_pc, if_pc_plus4, if_instr, exp_pc);
        end
        exp_pc += 32'd4;
        delivered++;
      end
      checks++;
      if (fault !== exp_fault) begin
        errors++; $display("FAIL rt_fault@%0d: got %b required %b", c, fault, exp_fault);
      end
    end
    checks++;
    if (delivered < 50) begin
      errors++; $display("FAIL rt_progress: got %0d deliveries required at least 50", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_redirect();
    test_wrap_fault();
    test_reset_midwait();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
